// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with an IF/ID output register and a
// one-entry skid buffer.
//
// The unit requests words from instruction memory at pc while in FETCH.
// A response is written straight into the output register when decode can
// take it. Otherwise it is parked in the skid buffer, and the unit stops
// requesting (FULL) until decode drains the output register. A redirect
// overrides everything in the cycle it is seen.
//
// Ports
//   clock, reset            : clock; asynchronous active-low reset
//   imem_req, imem_addr     : fetch request and word byte address
//   imem_ready, imem_data   : response valid for the current imem_addr, and its data
//   stall                   : decode cannot accept a new instruction
//   redirect, redirect_pc   : restart fetch at redirect_pc (bits [1:0] dropped)
//   instr, instr_pc,
//   instr_pc4, instr_valid  : IF/ID register
//   fetch_error             : sticky flag, set by a misaligned redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        instr_valid,
    output logic        fetch_error
);

    typedef enum logic {FETCH, FULL} state_t;

    state_t      state_q, state_d;
    logic        req_en_q, req_en_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] instr_pc4_q, instr_pc4_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_error_q, fetch_error_d;

    logic        out_free;
    logic        fire;

    // req_en_q is cleared by reset and set at the first clock edge. This keeps
    // imem_req low while reset is held and for the rest of the cycle in which
    // reset is released.
    assign imem_req  = req_en_q && (state_q == FETCH);
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_ready;
    assign out_free  = !instr_valid_q || !stall;

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_pc4   = instr_pc4_q;
    assign instr_valid = instr_valid_q;
    assign fetch_error = fetch_error_q;

    always_comb begin
        state_d       = state_q;
        req_en_d      = 1'b1;
        pc_d          = pc_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_pc4_d   = instr_pc4_q;
        instr_valid_d = instr_valid_q;
        fetch_error_d = fetch_error_q | (redirect && (redirect_pc[1:0] != 2'b00));

        if (redirect) begin
            // Returning to FETCH discards the skid entry. A response seen in
            // the same cycle is dropped because nothing is loaded here.
            pc_d          = {redirect_pc[31:2], 2'b00};
            instr_valid_d = 1'b0;
            state_d       = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (fire) begin
                        pc_d = pc_q + 32'd4;   // wraps modulo 2^32
                        if (out_free) begin
                            instr_d       = imem_data;
                            instr_pc_d    = pc_q;
                            instr_pc4_d   = pc_q + 32'd4;
                            instr_valid_d = 1'b1;
                        end else begin
                            skid_instr_d = imem_data;
                            skid_pc_d    = pc_q;
                            state_d      = FULL;
                        end
                    end else if (out_free) begin
                        instr_valid_d = 1'b0;
                    end
                end
                FULL: begin
                    // Only leave FULL when decode drains the current output.
                    if (!stall) begin
                        instr_d       = skid_instr_q;
                        instr_pc_d    = skid_pc_q;
                        instr_pc4_d   = skid_pc_q + 32'd4;
                        instr_valid_d = 1'b1;
                        state_d       = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH;
            req_en_q      <= 1'b0;
            pc_q          <= RESET_PC;
            skid_instr_q  <= 32'd0;
            skid_pc_q     <= 32'd0;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_pc4_q   <= 32'd0;
            instr_valid_q <= 1'b0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_en_q      <= req_en_d;
            pc_q          <= pc_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_pc4_q   <= instr_pc4_d;
            instr_valid_q <= instr_valid_d;
            fetch_error_q <= fetch_error_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus for fetch_unit.
//
// The reference model is a queue of instructions that have been fetched but
// not yet consumed by decode. Its entries are the output register and, when
// occupied, the skid entry. Fetching is allowed while fewer than two are held.
// A redirect empties the queue and restarts the expected address stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] instr, instr_pc, instr_pc4;
    logic        instr_valid, fetch_error;

    int n_chk  = 0;
    int n_fail = 0;
    bit mode   = 1'b0;   // 0: word = address, 1: scrambled word

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4),
        .instr_valid(instr_valid), .fetch_error(fetch_error)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a, input bit m);
        return m ? ((a * 32'h9E37_79B9) ^ 32'h5A5A_1234) : a;
    endfunction

    assign imem_data = memf(imem_addr, mode);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] q_pc[$];
    logic [31:0] q_w[$];
    logic [31:0] m_pc  = RST_PC;
    bit          m_err = 1'b0;
    bit          m_en  = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_pc.delete();
            q_w.delete();
            m_pc  = RST_PC;
            m_err = 1'b0;
            m_en  = 1'b0;
        end else begin
            bit req;
            req = m_en && (q_pc.size() < 2);
            if (redirect) begin
                q_pc.delete();
                q_w.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
            end else begin
                if (q_pc.size() > 0 && !stall) begin
                    void'(q_pc.pop_front());
                    void'(q_w.pop_front());
                end
                if (req && imem_ready) begin
                    q_pc.push_back(m_pc);
                    q_w.push_back(memf(m_pc, mode));
                    m_pc = m_pc + 32'd4;
                end
            end
            m_en = 1'b1;
        end
    end

    task automatic check_all();
        if (!reset) begin
            chk("rst_req",   {31'd0, imem_req}, 32'd0);
            chk("rst_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_pc",    instr_pc, 32'd0);
            chk("rst_pc4",   instr_pc4, 32'd0);
            chk("rst_err",   {31'd0, fetch_error}, 32'd0);
        end else begin
            chk("req", {31'd0, imem_req}, {31'd0, (m_en && q_pc.size() < 2)});
            if (imem_req) chk("addr", imem_addr, m_pc);
            chk("valid", {31'd0, instr_valid}, {31'd0, (q_pc.size() > 0)});
            if (q_pc.size() > 0) begin
                chk("instr", instr, q_w[0]);
                chk("instr_pc", instr_pc, q_pc[0]);
                chk("instr_pc4", instr_pc4, q_pc[0] + 32'd4);
            end
            chk("err", {31'd0, fetch_error}, {31'd0, m_err});
        end
    endtask

    // Drive one cycle of inputs, then check at the following falling edge.
    task automatic cyc(input bit r, input bit s, input bit d, input logic [31:0] p);
        imem_ready  = r;
        stall       = s;
        redirect    = d;
        redirect_pc = p;
        @(negedge clock);
        check_all();
    endtask

    initial begin
        int pulses;
        logic [31:0] p;

        // reset held
        repeat (2) cyc(0, 0, 0, 32'd0);
        reset = 1'b1;

        // streaming, word = address: outputs 0, 4, 8
        repeat (4) cyc(1, 0, 0, 32'd0);
        chk("stream_pc8", instr_pc, 32'h8);
        // stall at 0x8 while 0xC returns -> FULL
        cyc(1, 1, 0, 32'd0);
        chk("full_req", {31'd0, imem_req}, 32'd0);
        chk("full_hold", instr_pc, 32'h8);
        cyc(1, 1, 0, 32'd0);
        cyc(1, 0, 0, 32'd0);
        chk("drain_pc", instr_pc, 32'hC);
        chk("drain_addr", imem_addr, 32'h10);
        cyc(0, 0, 0, 32'd0);
        cyc(1, 0, 0, 32'd0);
        // redirect races the response for 0x14
        cyc(1, 0, 1, 32'h100);
        chk("redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        // misaligned redirect
        cyc(1, 0, 1, 32'h102);
        chk("mis_err", {31'd0, fetch_error}, 32'd1);
        chk("mis_addr", imem_addr, 32'h100);
        repeat (3) cyc(1, 0, 0, 32'd0);
        cyc(1, 0, 1, 32'h200);
        chk("err_sticky", {31'd0, fetch_error}, 32'd1);

        // slow memory: ready every third cycle
        mode   = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            cyc((i % 3) == 2, 0, 0, 32'd0);
            if (instr_valid) pulses++;
        end
        chk("slow_pulses", pulses, 32'd10);

        // address wrap
        cyc(1, 0, 1, 32'hFFFF_FFF4);
        repeat (5) cyc(1, 0, 0, 32'd0);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            p = $urandom;
            if ($urandom_range(3) != 0) p[1:0] = 2'b00;
            cyc($urandom_range(2) != 0, $urandom_range(2) == 0,
                $urandom_range(19) == 0, p);
        end

        // fill to FULL, then pulse reset between clock edges
        repeat (4) cyc(1, 1, 0, 32'd0);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_instr", instr, 32'd0);
        chk("async_pc",    instr_pc, 32'd0);
        chk("async_pc4",   instr_pc4, 32'd0);
        chk("async_err",   {31'd0, fetch_error}, 32'd0);
        chk("async_req",   {31'd0, imem_req}, 32'd0);
        #1 reset = 1'b1;
        cyc(1, 0, 0, 32'd0);
        chk("restart_addr", imem_addr, RST_PC);
        repeat (4) cyc(1, 0, 0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address of the first fetch after reset.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address of the requested word.
REQ-006 SHALL have port imem_ready, input, 1 bit: imem_data valid this cycle for the current imem_addr.
REQ-007 SHALL have port imem_data, input, 32 bits: instruction word returned by memory.
REQ-008 SHALL have port stall, input, 1 bit: decode cannot accept a new instruction this cycle.
REQ-009 SHALL have port redirect, input, 1 bit: taken branch/jump; restart fetch at redirect_pc.
REQ-010 SHALL have port redirect_pc, input, 32 bits: new fetch byte address.
REQ-011 SHALL have ports instr (32 bits), instr_pc (32 bits), instr_pc4 (32 bits) and instr_valid (1 bit), all outputs: the IF/ID register holding the instruction word, its address, its address + 4, and its valid flag.
REQ-012 SHALL have port fetch_error, output, 1 bit: sticky flag for a misaligned redirect.

Function
REQ-013 SHALL implement a two-state FSM, FETCH and FULL, plus a one-entry skid buffer (word, pc).
REQ-014 In FETCH, SHALL drive imem_req=1 and imem_addr=pc; in FULL, SHALL drive imem_req=0.
REQ-015 SHALL hold imem_addr constant while imem_req=1 and imem_ready=0, unless redirect=1.
REQ-016 The output register is "free" when instr_valid=0 or stall=0.
REQ-017 FETCH with imem_ready=1 and output free SHALL load instr=imem_data, instr_pc=pc, instr_pc4=pc+4, instr_valid=1, set pc=pc+4 and stay in FETCH; the response appears on the outputs the cycle after imem_ready.
REQ-018 FETCH with imem_ready=1 and output not free SHALL store the response into the skid buffer, set pc=pc+4 and go to FULL.
REQ-019 FETCH with imem_ready=0 and output free SHALL clear instr_valid; if the output is not free, SHALL hold all outputs.
REQ-020 FULL with stall=0 SHALL move the skid buffer into the output register (instr_valid=1) and return to FETCH; FULL with stall=1 SHALL hold everything.
REQ-021 While stall=1 and instr_valid=1, instr, instr_pc and instr_pc4 SHALL not change.
REQ-022 redirect=1 SHALL take priority over all other events that cycle: pc=redirect_pc with bits [1:0] cleared, instr_valid=0, skid buffer discarded, state to FETCH, and any same-cycle imem response dropped.
REQ-023 On redirect with redirect_pc[1:0]!=0, SHALL set fetch_error=1; fetch_error SHALL clear only on reset.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0) with no flag.
REQ-025 No instruction SHALL be duplicated or lost without a redirect; output order SHALL equal address order.

Reset
REQ-026 reset=0 SHALL immediately, independent of clock, set pc=RESET_PC, state=FETCH, instr_valid=0, instr=0, instr_pc=0, instr_pc4=0, fetch_error=0, and clear the skid buffer.
REQ-027 While reset=0, SHALL drive imem_req=0; the first request is issued at the first posedge after reset rises, with imem_addr=RESET_PC.
REQ-028 Reset asserted mid-operation SHALL abandon any outstanding request and skid contents.

Verification
REQ-029 Streaming, imem_ready=1 every cycle, stall=0, memory word = address: outputs (instr_pc, instr) = (0,0), (4,4), (8,8) on consecutive cycles, with instr_pc4 = instr_pc+4.
REQ-030 Stall with instr_valid=1 at pc 0x8 and a response for 0xC arriving: state goes FULL, imem_req=0, outputs hold 0x8; after stall drops, the next cycle shows 0xC and imem_addr=0x10.
REQ-031 Redirect to 0x100 in the same cycle as imem_ready for 0x14: the 0x14 word never appears, instr_valid=0 next cycle, and imem_addr=0x100.
REQ-032 Redirect to 0x102: fetch_error=1, imem_addr=0x100; fetch_error stays 1 through later redirects until reset.
REQ-033 Slow memory, imem_ready every third cycle: imem_addr is stable across wait cycles and instr_valid pulses once per word.
REQ-034 Async reset pulse between clock edges while in FULL: outputs clear immediately; after release, fetch restarts at RESET_PC; wrap test at 0xFFFF_FFFC gives a next fetch of 0x0.
